// File: rtl/voice_rom_arbiter_if.sv
// Voice-engine / sample-ROM bus seen by the arbiter: request side, ROM port and return path.
// The arbiter takes the slave view; voice engines and ROM model together take the master view.
interface voice_rom_arbiter_if #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8
);
    logic                         en;
    logic [NUM_VOICES-1:0]        req;
    logic [NUM_VOICES*ADDR_W-1:0] addr_in;
    logic [NUM_VOICES-1:0]        gnt;
    logic [ADDR_W-1:0]            rom_addr;
    logic                         rom_rd;
    logic [DATA_W-1:0]            rom_data;
    logic [DATA_W-1:0]            rd_data;
    logic [NUM_VOICES-1:0]        rd_valid;

    modport master (
        output en, req, addr_in, rom_data,
        input  gnt, rom_addr, rom_rd, rd_data, rd_valid
    );

    modport slave (
        input  en, req, addr_in, rom_data,
        output gnt, rom_addr, rom_rd, rd_data, rd_valid
    );
endinterface

// File: rtl/voice_rom_arbiter.sv
// Round-robin sharing of one sample ROM among the drum voices; grant 1 cycle after req, data ROM_LAT+1 after grant.
// No backpressure: voices hold req until their one-cycle gnt pulse, returns always delivered.
module voice_rom_arbiter #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int ROM_LAT    = 2
) (
    input  logic               clk,
    input  logic               reset,
    voice_rom_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [PTR_W-1:0]                   ptr_q, ptr_d;
    logic [NUM_VOICES-1:0]              mask_q, mask_d;
    logic [NUM_VOICES-1:0]              gnt_q, gnt_d;
    logic [ADDR_W-1:0]                  rom_addr_q, rom_addr_d;
    logic                               rom_rd_q, rom_rd_d;
    logic [ROM_LAT:0][NUM_VOICES-1:0]   tag_q, tag_d;
    logic [DATA_W-1:0]                  rd_data_q, rd_data_d;
    logic [NUM_VOICES-1:0]              rd_valid_q, rd_valid_d;

    logic [NUM_VOICES-1:0] elig;
    logic [NUM_VOICES-1:0] k_oh;
    logic [PTR_W-1:0]      k;
    logic                  found;
    int                    idx;

    // First eligible voice at or after the pointer, wrapping around.
    always_comb begin
        elig  = bus.req & ~mask_q;
        found = 1'b0;
        k     = '0;
        idx   = 0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            idx = (int'(ptr_q) + i) % NUM_VOICES;
            if (!found && elig[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                k     = idx[PTR_W-1:0];
            end
        end
        k_oh = NUM_VOICES'(1) << k;
    end

    always_comb begin
        gnt_d      = '0;
        rom_rd_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        ptr_d      = ptr_q;
        mask_d     = '0;
        if (bus.en && found) begin
            gnt_d      = k_oh;
            rom_rd_d   = 1'b1;
            rom_addr_d = bus.addr_in[int'(k)*ADDR_W +: ADDR_W];
            ptr_d      = (k == PTR_W'(NUM_VOICES-1)) ? '0 : k + 1'b1;
            mask_d     = k_oh;
        end
    end

    // The tag rides alongside the ROM read; its exit marks the cycle rom_data is valid.
    always_comb begin
        tag_d      = {tag_q[ROM_LAT-1:0], gnt_d};
        rd_valid_d = tag_q[ROM_LAT];
        rd_data_d  = (|tag_q[ROM_LAT]) ? bus.rom_data : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            mask_q     <= '0;
            gnt_q      <= '0;
            rom_addr_q <= '0;
            rom_rd_q   <= 1'b0;
            tag_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            mask_q     <= mask_d;
            gnt_q      <= gnt_d;
            rom_addr_q <= rom_addr_d;
            rom_rd_q   <= rom_rd_d;
            tag_q      <= tag_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_rd   = rom_rd_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_voice_rom_arbiter.sv
// Bench for voice_rom_arbiter: table of per-cycle vectors plus hand sequences, with a return-path scoreboard.
module tb_voice_rom_arbiter;
    localparam int NV  = 4;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    voice_rom_arbiter_if #(.NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW)) bus();

    voice_rom_arbiter #(.NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [DW-1:0] romf(logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h78;
    endfunction

    // ROM model: LAT register stages from rom_rd to rom_data.
    logic [DW-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= bus.rom_rd ? romf(bus.rom_addr) : 8'h00;
        for (int s = 1; s < LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
    end
    assign bus.rom_data = rom_pipe[LAT-1];

    typedef struct {
        logic [NV-1:0] tag;
        logic [DW-1:0] data;
        int            due;
    } ret_t;

    typedef struct {
        logic          rst;
        logic          en;
        logic [NV-1:0] req;
        logic [NV-1:0] gnt;
    } vec_t;

    ret_t          sbq[$];
    vec_t          tbl [18];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [AW-1:0] va [NV];
    logic [DW-1:0] exp_rd_data = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(logic r, logic e, logic [NV-1:0] q);
        reset   = r;
        bus.en  = e;
        bus.req = q;
        for (int i = 0; i < NV; i++) bus.addr_in[i*AW +: AW] = va[i];
    endtask

    // One clock: check the return path against the scoreboard, then the grant outputs.
    task automatic step(logic [NV-1:0] exp_gnt);
        int   k;
        ret_t e;
        if (reset) begin
            sbq.delete();
            exp_rd_data = '0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            check("rd_valid", 32'(bus.rd_valid), 32'(sbq[0].tag));
            check("rd_data", 32'(bus.rd_data), 32'(sbq[0].data));
            exp_rd_data = sbq[0].data;
            void'(sbq.pop_front());
        end else begin
            check("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
            check("rd_data_hold", 32'(bus.rd_data), 32'(exp_rd_data));
        end
        check("gnt", 32'(bus.gnt), 32'(exp_gnt));
        check("rom_rd", 32'(bus.rom_rd), 32'(exp_gnt != '0));
        if (exp_gnt != '0) begin
            k = 0;
            for (int i = 0; i < NV; i++) if (exp_gnt[i]) k = i;
            check("rom_addr", 32'(bus.rom_addr), 32'(va[k]));
            e.tag  = exp_gnt;
            e.data = romf(va[k]);
            e.due  = cyc + LAT + 1;
            sbq.push_back(e);
        end
    endtask

    initial begin
        for (int i = 0; i < NV; i++) va[i] = '0;
        drive(1'b1, 1'b0, '0);

        // reset held with all requesting, then all-request rotation, then a lone hammering voice
        tbl[0]  = '{1'b1, 1'b1, 4'b1111, 4'b0000};
        tbl[1]  = '{1'b1, 1'b1, 4'b1111, 4'b0000};
        tbl[2]  = '{1'b1, 1'b1, 4'b1111, 4'b0000};
        tbl[3]  = '{1'b0, 1'b1, 4'b1111, 4'b0001};
        tbl[4]  = '{1'b0, 1'b1, 4'b1111, 4'b0010};
        tbl[5]  = '{1'b0, 1'b1, 4'b1111, 4'b0100};
        tbl[6]  = '{1'b0, 1'b1, 4'b1111, 4'b1000};
        tbl[7]  = '{1'b0, 1'b1, 4'b1111, 4'b0001};
        tbl[8]  = '{1'b0, 1'b1, 4'b1111, 4'b0010};
        tbl[9]  = '{1'b0, 1'b1, 4'b1111, 4'b0100};
        tbl[10] = '{1'b0, 1'b1, 4'b1111, 4'b1000};
        tbl[11] = '{1'b0, 1'b1, 4'b0010, 4'b0010};
        tbl[12] = '{1'b0, 1'b1, 4'b0010, 4'b0000};
        tbl[13] = '{1'b0, 1'b1, 4'b0010, 4'b0010};
        tbl[14] = '{1'b0, 1'b1, 4'b0010, 4'b0000};
        tbl[15] = '{1'b0, 1'b1, 4'b0010, 4'b0010};
        tbl[16] = '{1'b0, 1'b1, 4'b0010, 4'b0000};
        tbl[17] = '{1'b0, 1'b1, 4'b0000, 4'b0000};

        for (int r = 0; r < 18; r++) begin
            for (int i = 0; i < NV; i++) va[i] = 16'(i * 16'h1000 + r * 3 + 1);
            drive(tbl[r].rst, tbl[r].en, tbl[r].req);
            step(tbl[r].gnt);
        end

        // single request from the hat voice, known ROM byte
        va[2] = 16'h0123;
        drive(1'b0, 1'b1, 4'b0100);
        step(4'b0100);
        check("t2_rom_addr", 32'(bus.rom_addr), 32'h0123);
        drive(1'b0, 1'b1, 4'b0000);
        step(4'b0000);
        step(4'b0000);
        step(4'b0000);
        check("t2_rd_valid", 32'(bus.rd_valid), 32'b0100);
        check("t2_rd_data", 32'(bus.rd_data), 32'h5A);

        // two reads in flight, then en low: returns still arrive, no grants, pointer frozen
        va[0] = 16'h1111;
        va[1] = 16'h4321;
        drive(1'b0, 1'b1, 4'b0011);
        step(4'b0001);
        va[0] = 16'h2222;
        drive(1'b0, 1'b1, 4'b0011);
        step(4'b0010);
        drive(1'b0, 1'b0, 4'b1111);
        repeat (4) step(4'b0000);
        drive(1'b0, 1'b1, 4'b1111);
        step(4'b0100);
        drive(1'b0, 1'b1, 4'b0000);
        step(4'b0000);

        // reset one cycle after a grant discards the in-flight read
        va[3] = 16'hBEEF;
        drive(1'b0, 1'b1, 4'b1000);
        step(4'b1000);
        drive(1'b1, 1'b1, 4'b0000);
        step(4'b0000);
        check("t6_rom_addr", 32'(bus.rom_addr), 32'h0);
        check("t6_rd_data", 32'(bus.rd_data), 32'h0);
        drive(1'b0, 1'b1, 4'b0000);
        repeat (4) step(4'b0000);
        drive(1'b0, 1'b1, 4'b1111);
        step(4'b0001);
        drive(1'b0, 1'b1, 4'b0000);
        repeat (4) step(4'b0000);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/voice_rom_arbiter.md
Name: voice_rom_arbiter

Overview:
- Shares one synchronous sample ROM among the four drum voice engines (snare, kick, hat, clap).
- Each voice streams sample bytes by issuing read requests to this block.
- Requests are granted round-robin, at most one ROM read per cycle.
- Returned data is routed to the originating voice after the fixed ROM latency; the block sits between the voice engines and the ROM, ahead of the mixer.

Parameters:
NUM_VOICES, 4, number of requesting voices (index 0 = snare, 1 = kick, 2 = hat, 3 = clap)
ADDR_W, 16, ROM address width
DATA_W, 8, ROM data / sample width
ROM_LAT, 2, cycles from rom_rd asserted to rom_data valid (≥1)

Ports:
clk  input  1  system clock (CLOCK_50 domain)
reset  input  1  synchronous, active-high reset
en  input  1  play enable; new grants issued only while high
req  input  NUM_VOICES  per-voice read request, level, held until granted
addr_in  input  NUM_VOICES*ADDR_W  per-voice addresses, voice i at bits [i*ADDR_W +: ADDR_W]
gnt  output  NUM_VOICES  one-hot grant pulse, registered
rom_addr  output  ADDR_W  address to ROM, registered
rom_rd  output  1  ROM read strobe, registered
rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd
rd_data  output  DATA_W  returned sample byte, registered
rd_valid  output  NUM_VOICES  one-hot: rd_data belongs to voice i, one-cycle pulse

Behaviour:
- **Reset values:**
  - gnt=0, rom_rd=0, rom_addr=0, rd_data=0, rd_valid=0.
  - Round-robin pointer=0, grant mask=0.
  - Tag pipeline cleared, so in-flight reads are discarded and never produce rd_valid.
  - Reset wins over all other inputs in the same cycle.
- **Arbitration (each rising edge, reset low):**
  - Eligible set E = req & ~mask.
  - If en=1 and E≠0, pick the first set bit of E searching from pointer upward, modulo NUM_VOICES. Call it k.
  - Next cycle: gnt=one-hot(k), rom_addr=addr_in[k], rom_rd=1, pointer=(k+1) mod NUM_VOICES, mask=one-hot(k).
  - Otherwise: gnt=0, rom_rd=0, rom_addr holds, pointer holds, mask=0.
- **Handshake:**
  - A voice keeps req and its address stable until it sees its gnt bit.
  - It may drop req, or keep it high for the next byte with a new address, on the edge after gnt.
  - The mask blocks voice k in the cycle its gnt is high. A voice therefore gets at most one grant every 2 cycles, with no double grant from a stale req.
  - Other voices are unaffected by the mask, so the ROM port sustains 1 read/cycle when ≥2 voices request.
- **Fairness:** a continuously requesting voice is granted within NUM_VOICES cycles of req rising (en=1).
- **Return path:**
  - Tag shift register, ROM_LAT+1 stages deep, carries one-hot(k) alongside rom_rd.
  - Exactly ROM_LAT+1 cycles after the grant cycle: rd_valid=tag and rd_data=rom_data, sampled when the tag exits.
  - Total latency: req sampled at edge t → gnt at t+1 → rd_valid at t+2+ROM_LAT.
  - When no tag exits, rd_valid=0 and rd_data holds its last value.
- **en deasserted:**
  - No new grants; the pointer is frozen.
  - Reads already issued still complete and deliver rd_valid.
  - req from voices is ignored, not latched. Arbitration resumes on the first edge with en=1 using the frozen pointer.
- **Address width:** rom_addr is a direct copy; no arithmetic. The block never wraps addresses; the voice owns address sequencing.
- **Ordering:** per-voice return order equals grant order. Returns never collide, since at most one read is issued per cycle.

Test Plan:
1. Reset held 3 cycles with req=4'b1111, en=1 → gnt, rom_rd, rd_valid all 0 during reset. First grant after release is voice 0.
2. Single request: req=4'b0100, addr_in voice2=16'h0123, ROM returns 8'h5A, ROM_LAT=2 → gnt=4'b0100 and rom_addr=16'h0123 one cycle later. rd_valid=4'b0100 with rd_data=8'h5A three cycles after gnt.
3. All voices requesting continuously from reset → gnt sequence 0001,0010,0100,1000,0001…, rom_rd high every cycle, rd_valid repeats the same sequence delayed ROM_LAT+1 cycles.
4. Only voice 1 holds req high continuously → gnt=4'b0010 every other cycle, rom_rd duty 50%, never two consecutive grants.
5. Two reads in flight, then en dropped → both rd_valid pulses still appear on schedule. No gnt while en=0. On en=1, the next grant goes to the voice after the last granted one.
6. Reset asserted one cycle after a grant (read in flight) → no rd_valid for that read. All outputs are 0 the cycle after reset.
